// File: rtl/pmp_csr_regs.sv
// rtl/pmp_csr_regs.sv - PMP pmpcfg/pmpaddr CSR storage with WARL legalization, lock rules and read-back
module pmp_csr_regs #(
   parameter int XLEN        = 64,
   parameter int PA_BITS     = 56,
   parameter int PMP_ENTRIES = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               CSRMWriteM,
   input  logic [11:0]                        CSRAdrM,
   input  logic [XLEN-1:0]                    CSRWriteValM,
   output logic [8*PMP_ENTRIES-1:0]           PMPCfgArray,
   output logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdrArray,
   output logic [XLEN-1:0]                    CSRReadValM,
   output logic                               IllegalPMPAccessM,
   output logic                               PMPUpdateM
);

   localparam int AW = PA_BITS - 2;
   // At least one storage slot keeps the arrays legal when no entries exist; it is never written.
   localparam int NS = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;

   logic [7:0]    cfg_q [NS];
   logic [AW-1:0] adr_q [NS];
   logic [7:0]    cfg_d [NS];
   logic [AW-1:0] adr_d [NS];
   logic [NS-1:0] tor_lock;
   logic          in_range;
   logic          cfg_sel;
   logic          adr_sel;
   logic [3:0]    cfg_n;
   logic [6:0]    adr_idx;
   logic          changed;
   logic          update_q;
   logic          unused_bits;

   assign unused_bits = ^CSRWriteValM[XLEN-1:AW];

   always_comb begin
      in_range = (CSRAdrM >= 12'h3A0) && (CSRAdrM <= 12'h3EF);
      cfg_n    = CSRAdrM[3:0];
      cfg_sel  = (CSRAdrM[11:4] == 8'h3A) && !cfg_n[0] && (int'(cfg_n) < PMP_ENTRIES / 4);
      adr_idx  = 7'(CSRAdrM - 12'h3B0);
      adr_sel  = in_range && (CSRAdrM >= 12'h3B0) && (int'(adr_idx) < PMP_ENTRIES);
   end

   assign IllegalPMPAccessM = in_range && !cfg_sel && !adr_sel;

   // A locked TOR entry above protects the base address held in the entry below it.
   generate
      for (genvar i = 0; i < NS; i++) begin : g_tor
         if (i + 1 < PMP_ENTRIES) begin : g_above
            assign tor_lock[i] = cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01);
         end else begin : g_top
            assign tor_lock[i] = 1'b0;
         end
      end
   endgenerate

   function automatic logic [7:0] legal_cfg(input logic [7:0] cur, input logic [7:0] nb);
      if (cur[7] || (nb[1] && !nb[0]))
         return cur;
      return {nb[7], 2'b00, nb[4:0]};
   endfunction

   always_comb begin
      changed = 1'b0;
      for (int i = 0; i < NS; i++) begin
         cfg_d[i] = cfg_q[i];
         adr_d[i] = adr_q[i];
         if (i < PMP_ENTRIES && CSRMWriteM) begin
            if (cfg_sel && (i / 8 == int'(cfg_n[3:1])))
               cfg_d[i] = legal_cfg(cfg_q[i], CSRWriteValM[8*(i%8) +: 8]);
            if (adr_sel && (i == int'(adr_idx)) && !cfg_q[i][7] && !tor_lock[i])
               adr_d[i] = CSRWriteValM[AW-1:0];
         end
         changed = changed || (cfg_d[i] != cfg_q[i]) || (adr_d[i] != adr_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NS; i++) begin
            cfg_q[i] <= '0;
            adr_q[i] <= '0;
         end
         update_q <= 1'b0;
      end else begin
         cfg_q    <= cfg_d;
         adr_q    <= adr_d;
         update_q <= CSRMWriteM && changed;
      end
   end

   assign PMPUpdateM = update_q;

   always_comb begin
      CSRReadValM = '0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         if (cfg_sel && (i / 8 == int'(cfg_n[3:1])))
            CSRReadValM[8*(i%8) +: 8] = cfg_q[i];
         if (adr_sel && (i == int'(adr_idx)))
            CSRReadValM = XLEN'(adr_q[i]);
      end
   end

   generate
      if (PMP_ENTRIES > 0) begin : g_flat
         for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_ent
            assign PMPCfgArray[8*i +: 8]   = cfg_q[i];
            assign PMPAdrArray[AW*i +: AW] = adr_q[i];
         end
      end else begin : g_empty
         assign PMPCfgArray = '0;
         assign PMPAdrArray = '0;
      end
   endgenerate

endmodule

// File: tb/tb_pmp_csr_regs.sv
// tb/tb_pmp_csr_regs.sv - directed bench for pmp_csr_regs with a spec-level reference model
module tb_pmp_csr_regs;

   localparam int XLEN = 64;
   localparam int PA   = 56;
   localparam int NE   = 16;
   localparam int AW   = PA - 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              CSRMWriteM;
   logic [11:0]       CSRAdrM;
   logic [XLEN-1:0]   CSRWriteValM;
   logic [8*NE-1:0]   PMPCfgArray;
   logic [AW*NE-1:0]  PMPAdrArray;
   logic [XLEN-1:0]   CSRReadValM;
   logic              IllegalPMPAccessM;
   logic              PMPUpdateM;

   always #5 clk = ~clk;

   pmp_csr_regs #(.XLEN(XLEN), .PA_BITS(PA), .PMP_ENTRIES(NE)) dut (
      .clk(clk),
      .reset(reset),
      .CSRMWriteM(CSRMWriteM),
      .CSRAdrM(CSRAdrM),
      .CSRWriteValM(CSRWriteValM),
      .PMPCfgArray(PMPCfgArray),
      .PMPAdrArray(PMPAdrArray),
      .CSRReadValM(CSRReadValM),
      .IllegalPMPAccessM(IllegalPMPAccessM),
      .PMPUpdateM(PMPUpdateM)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [7:0]    m_cfg [NE];
   logic [AW-1:0] m_adr [NE];
   logic          m_upd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_read(input logic [11:0] a);
      int n;
      logic [63:0] r;
      r = '0;
      if (a >= 12'h3A0 && a <= 12'h3AF) begin
         n = int'(a) - 'h3A0;
         if (n % 2 == 0 && n < NE / 4)
            for (int b = 0; b < 8; b++) r[8*b +: 8] = m_cfg[4*n + b];
      end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
         n = int'(a) - 'h3B0;
         if (n < NE) r = {10'b0, m_adr[n]};
      end
      return r;
   endfunction

   function automatic logic exp_ill(input logic [11:0] a);
      int n;
      if (a >= 12'h3A0 && a <= 12'h3AF) begin
         n = int'(a) - 'h3A0;
         return !(n % 2 == 0 && n < NE / 4);
      end
      if (a >= 12'h3B0 && a <= 12'h3EF) begin
         n = int'(a) - 'h3B0;
         return n >= NE;
      end
      return 1'b0;
   endfunction

   // Reference model: applies the write rules to a copy of the pre-write state.
   always @(posedge clk) begin
      logic [7:0]    nc [NE];
      logic [AW-1:0] na [NE];
      logic [7:0]    nb;
      int            n;
      bit            diff;
      if (reset) begin
         for (int i = 0; i < NE; i++) begin
            m_cfg[i] = '0;
            m_adr[i] = '0;
         end
         m_upd = 1'b0;
      end else begin
         for (int i = 0; i < NE; i++) begin
            nc[i] = m_cfg[i];
            na[i] = m_adr[i];
         end
         if (CSRMWriteM && !exp_ill(CSRAdrM)) begin
            if (CSRAdrM >= 12'h3A0 && CSRAdrM <= 12'h3AF) begin
               n = int'(CSRAdrM) - 'h3A0;
               for (int b = 0; b < 8; b++) begin
                  nb = CSRWriteValM[8*b +: 8];
                  if (m_cfg[4*n+b][7] == 1'b0 && !(nb[1] == 1'b1 && nb[0] == 1'b0))
                     nc[4*n+b] = nb & 8'h9F;
               end
            end else if (CSRAdrM >= 12'h3B0 && CSRAdrM <= 12'h3EF) begin
               n = int'(CSRAdrM) - 'h3B0;
               if (!(m_cfg[n][7] ||
                     (n + 1 < NE && m_cfg[n+1][7] && m_cfg[n+1][4:3] == 2'b01)))
                  na[n] = CSRWriteValM[AW-1:0];
            end
         end
         diff = 1'b0;
         for (int i = 0; i < NE; i++) begin
            if (nc[i] != m_cfg[i] || na[i] != m_adr[i]) diff = 1'b1;
            m_cfg[i] = nc[i];
            m_adr[i] = na[i];
         end
         m_upd = diff;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("read", CSRReadValM, exp_read(CSRAdrM));
         chk("illegal", 64'(IllegalPMPAccessM), 64'(exp_ill(CSRAdrM)));
         chk("update", 64'(PMPUpdateM), 64'(m_upd));
         for (int i = 0; i < NE; i++) begin
            chk($sformatf("cfg_arr[%0d]", i), 64'(PMPCfgArray[8*i +: 8]), 64'(m_cfg[i]));
            chk($sformatf("adr_arr[%0d]", i), 64'(PMPAdrArray[AW*i +: AW]), 64'(m_adr[i]));
         end
      end
   end

   task automatic wr(input logic [11:0] a, input logic [63:0] v);
      CSRMWriteM   = 1'b1;
      CSRAdrM      = a;
      CSRWriteValM = v;
      @(posedge clk);
      #1;
      CSRMWriteM   = 1'b0;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp, input logic ill);
      CSRAdrM = a;
      #1;
      chk(name, CSRReadValM, exp);
      chk({name, "_ill"}, 64'(IllegalPMPAccessM), 64'(ill));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [11:0] a;
      logic [63:0] v;
      reset        = 1'b1;
      CSRMWriteM   = 1'b0;
      CSRAdrM      = 12'h3A0;
      CSRWriteValM = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_cfg", 64'(PMPCfgArray[63:0]), 64'h0);
      chk("reset_upd", 64'(PMPUpdateM), 64'h0);
      rd("reset_rd", 12'h3A0, 64'h0, 1'b0);

      // basic cfg write
      wr(12'h3A0, 64'h0F0B);
      chk("t1_upd", 64'(PMPUpdateM), 64'h1);
      rd("t1_rd", 12'h3A0, 64'h0F0B, 1'b0);
      chk("t1_b1", 64'(PMPCfgArray[15:8]), 64'h0F);
      chk("t1_b0", 64'(PMPCfgArray[7:0]), 64'h0B);

      // lock blocks both cfg and addr of the same entry
      wr(12'h3B0, 64'h55);
      wr(12'h3A0, 64'h9F);
      rd("t2_lock", 12'h3A0, 64'h9F, 1'b0);
      wr(12'h3A0, 64'h0);
      chk("t2_upd_cfg", 64'(PMPUpdateM), 64'h0);
      wr(12'h3B0, 64'h1234);
      chk("t2_upd_adr", 64'(PMPUpdateM), 64'h0);
      rd("t2_adr", 12'h3B0, 64'h55, 1'b0);

      // locked TOR entry above protects pmpaddr below
      do_reset();
      wr(12'h3A0, 64'h8900);
      wr(12'h3B0, 64'hABC);
      chk("t3_upd", 64'(PMPUpdateM), 64'h0);
      rd("t3_blk", 12'h3B0, 64'h0, 1'b0);
      do_reset();
      wr(12'h3B0, 64'hABC);
      chk("t3_upd2", 64'(PMPUpdateM), 64'h1);
      rd("t3_ok", 12'h3B0, 64'hABC, 1'b0);

      // reserved W=1,R=0 combination and reserved bits
      wr(12'h3A0, 64'h05_0000);
      wr(12'h3A0, 64'h62_0000);
      chk("t4_upd", 64'(PMPUpdateM), 64'h0);
      rd("t4_keep", 12'h3A0, 64'h05_0000, 1'b0);
      wr(12'h3A0, 64'h63_0000);
      chk("t4_upd2", 64'(PMPUpdateM), 64'h1);
      rd("t4_new", 12'h3A0, 64'h03_0000, 1'b0);

      // unimplemented and out-of-range addresses
      rd("t5_cfg1", 12'h3A1, 64'h0, 1'b1);
      wr(12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t5_upd", 64'(PMPUpdateM), 64'h0);
      rd("t5_adr20", 12'h3C4, 64'h0, 1'b1);
      rd("t5_cfg4", 12'h3A4, 64'h0, 1'b1);
      rd("t5_cfg2", 12'h3A2, 64'h0, 1'b0);
      rd("t5_top", 12'h3EF, 64'h0, 1'b1);
      rd("t5_above", 12'h3F0, 64'h0, 1'b0);
      rd("t5_below", 12'h39F, 64'h0, 1'b0);
      wr(12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF);
      rd("t5_adr3", 12'h3B3, 64'h003F_FFFF_FFFF_FFFF, 1'b0);

      // back-to-back changes, identical data, discarded upper bits
      wr(12'h3B4, 64'h1);
      chk("bb_upd1", 64'(PMPUpdateM), 64'h1);
      wr(12'h3B5, 64'h2);
      chk("bb_upd2", 64'(PMPUpdateM), 64'h1);
      wr(12'h3B4, 64'h1);
      chk("same_upd", 64'(PMPUpdateM), 64'h0);
      wr(12'h3B4, 64'h1000_0000_0000_0001);
      chk("upper_upd", 64'(PMPUpdateM), 64'h0);

      // locked TOR on the last entry guards entries 15 and 14
      wr(12'h3A2, 64'h8F00_0000_0000_0000);
      wr(12'h3BF, 64'h5);
      wr(12'h3BE, 64'h5);
      chk("t15_upd", 64'(PMPUpdateM), 64'h0);
      rd("t15_adr14", 12'h3BE, 64'h0, 1'b0);
      wr(12'h3BD, 64'h7);
      rd("t15_adr13", 12'h3BD, 64'h7, 1'b0);

      // reset wins over a simultaneous write
      CSRMWriteM   = 1'b1;
      CSRAdrM      = 12'h3B1;
      CSRWriteValM = 64'h7;
      reset        = 1'b1;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      CSRMWriteM = 1'b0;
      chk("t6_upd", 64'(PMPUpdateM), 64'h0);
      chk("t6_cfg", 64'(|PMPCfgArray), 64'h0);
      chk("t6_adr", 64'(|PMPAdrArray), 64'h0);
      rd("t6_rd", 12'h3B1, 64'h0, 1'b0);

      // mixed sweep checked by the model each cycle
      for (int k = 0; k < 80; k++) begin
         if (k % 20 == 19) do_reset();
         a = 12'(12'h3A0 + $urandom_range(0, 79));
         v = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) v = v & 64'h7F7F_7F7F_7F7F_7F7F;
         wr(a, v);
         CSRAdrM = 12'(12'h3A0 + $urandom_range(0, 79));
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmp_csr_regs.md
Name: pmp_csr_regs

Overview:
- Write/read side of the PMP: owns the pmpcfg and pmpaddr CSR state that the per-entry PMP address decoders consume.
- Decodes M-mode CSR writes, applies WARL legalization and lock rules, and stores the entries.
- Drives flattened cfg and address arrays to the PMP checker.
- Provides CSR read-back and a registered update pulse for downstream flush logic.

Parameters:
- XLEN, 64, CSR data width; only 64 is supported.
- PA_BITS, 56, physical address width; each pmpaddr register stores PA_BITS-2 bits.
- PMP_ENTRIES, 16, number of entries; legal values are 0, 16 and 64, and the value must be a multiple of 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- CSRMWriteM  in  1  M-mode CSR write strobe
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  value to write
- PMPCfgArray  out  8*PMP_ENTRIES  cfg byte i at bits [8i+7:8i]
- PMPAdrArray  out  (PA_BITS-2)*PMP_ENTRIES  pmpaddr i at slice i
- CSRReadValM  out  XLEN  combinational read data for CSRAdrM
- IllegalPMPAccessM  out  1  CSRAdrM is in the PMP range but not implemented
- PMPUpdateM  out  1  one-cycle pulse, registered, the cycle after any accepted write changes state

Behaviour:
- Reset (synchronous, active-high, at the clk edge):
  - All cfg bytes are 0 and all pmpaddr registers are 0.
  - PMPUpdateM is 0.
  - Lock bits are cleared only by reset.
- Address map:
  - pmpcfgN is at 0x3A0+N. Only even N below PMP_ENTRIES/4 are implemented.
  - pmpcfgN holds cfg bytes 4N to 4N+7 in ascending byte order.
  - pmpaddrI is at 0x3B0+I, for I < PMP_ENTRIES.
- Unimplemented PMP addresses:
  - Covers odd pmpcfg, out-of-range pmpcfg, and pmpaddr with I >= PMP_ENTRIES, all within 0x3A0-0x3EF.
  - IllegalPMPAccessM=1; the write is ignored and the read returns 0.
  - Addresses outside 0x3A0-0x3EF give IllegalPMPAccessM=0 and CSRReadValM=0.
- Write timing: the state update lands on the clk edge where CSRMWriteM=1. A same-cycle read returns the old value; the new value is visible the next cycle.
- Cfg byte legalization, applied independently for each of the 8 bytes:
  - Byte i is unchanged if the current cfg[i].L (bit 7) is 1.
  - Byte i is unchanged if the new byte has W=1 and R=0 (reserved combination).
  - Otherwise bits [6:5] are forced to 0 and the remaining bits are taken from the write.
- pmpaddr write: register I is written with CSRWriteValM[PA_BITS-3:0]; upper bits are discarded. The write is ignored if either:
  - cfg[I].L=1, or
  - I+1 < PMP_ENTRIES and cfg[I+1].L=1 and cfg[I+1].A=01 (TOR).
- Lock semantics use pre-write state. A single pmpcfg write that sets L on byte i still writes byte i.
- Read-back:
  - pmpcfg returns the stored 8 bytes.
  - pmpaddr returns {zero-extend, stored value}.
  - Reserved cfg bits read 0.
- PMPUpdateM is registered:
  - It is 1 in cycle t+1 iff a write in cycle t changed at least one stored bit.
  - A write fully blocked by lock or legalization, or one writing identical data, gives 0.
  - Back-to-back changing writes hold it high on consecutive cycles.
- If reset is asserted in the same cycle as a write, reset wins.
- PMP_ENTRIES=0: no state, all arrays are empty, and every PMP-range address is illegal.

Test Plan:
1. Reset, then write pmpcfg0=0x0000_0000_0000_0F0B and read next cycle:
   - Read returns 0x0F0B; byte1=0x0F, byte0=0x0B.
   - PMPUpdateM=1 in the cycle after the write.
2. Write byte0=0x9F (L=1, NAPOT, RWX), then write pmpcfg0 byte0=0x00 and pmpaddr0=0x1234:
   - Byte0 stays 0x9F and pmpaddr0 stays at its prior value.
   - PMPUpdateM=0 after the blocked writes.
3. Set cfg1=0x89 (L, TOR, R), then write pmpaddr0=0xABC:
   - Write is ignored.
   - Clearing L via reset and repeating the write stores 0xABC.
4. Write pmpcfg0 byte2=0x62 (W=1, R=0, reserved bits set): byte2 is unchanged. Write 0x63 instead: it stores 0x03.
5. Access pmpcfg1 (0x3A1) and pmpaddr20 with PMP_ENTRIES=16:
   - IllegalPMPAccessM=1, read=0, no state change.
   - Write pmpaddr3=0xFFFF_FFFF_FFFF_FFFF: read returns 2^54-1.
6. Issue a write and reset in the same cycle: all outputs are 0 the next cycle and PMPUpdateM=0.
